fp32_dot_accumulator: RTL and testbench
=======================================

// Module: fp32_dot_accumulator
// PURPOSE
//  Downstream consumer of the FP32 multiplier: accepts its product stream (dataout/dataout_valid/overflow_flag)
//  and accumulates VEC_LEN consecutive products into one IEEE-754 single-precision sum (dot product).
//  Multi-cycle FSM adder (align/add/normalise); emits one result per VEC_LEN accepted products.
// PARAMETERS
//  VEC_LEN  4  products per dot product (>=2); CNT_W = $clog2(VEC_LEN) internal localparam
// PORTS
//  clk            in   1   single clock, rising edge
//  reset          in   1   asynchronous, active-low reset (0 = reset)
//  datain_valid   in   1   product present on datain (multiplier dataout_valid)
//  datain         in   32  FP32 product (multiplier dataout)
//  datain_ovf     in   1   product overflowed upstream (multiplier overflow_flag)
//  datain_ready   out  1   block can accept a product this cycle
//  dataout        out  32  FP32 accumulated sum
//  dataout_valid  out  1   one-cycle pulse: dataout holds a new sum
//  overflow_flag  out  1   sum saturated to infinity (valid with dataout_valid, held with dataout)
// BEHAVIOUR
//  Reset: state=IDLE, acc=+0, count=0, ovf_sticky=0; datain_ready=1, dataout=0, dataout_valid=0, overflow_flag=0.
//  Handshake: element accepted on edge where datain_valid&datain_ready; ready=1 only in IDLE, so valid held
//   N cycles is accepted once per IDLE visit; products dropped while ready=0 are the upstream's responsibility.
//  FSM: IDLE -(accept)-> ALIGN -> ADD -> NORM -> IDLE (count<VEC_LEN-1) | DONE (count==VEC_LEN-1); DONE -> IDLE.
//   Per-element occupancy 4 cycles (accept edge to next ready=1); last element: dataout_valid high in the
//   cycle after NORM, i.e. 4th cycle after accept edge, for exactly one cycle; acc/count/sticky cleared on DONE exit.
//  ALIGN: unpack acc and operand (hidden bit 1, 24-bit mantissa); larger exponent wins; smaller mantissa shifted
//   right by exponent difference, shift >=25 yields 0; bits shifted out are truncated (round-toward-zero).
//  ADD: equal signs -> 25-bit sum; differing signs -> larger-magnitude minus smaller, sign of larger magnitude.
//  NORM: carry bit set -> shift right 1, exp+1; else left shift by leading-zero count, exp-=lzc.
//   Exact zero -> +0 (0x00000000). exp<=0 after normalise -> flush to +/-0, no flag.
//   exp>=255 -> acc=sign|0x7F800000, ovf_sticky=1.
//  Operand rules: exponent field 0 -> treated as 0 (denormals flushed); exponent 255 or datain_ovf=1 ->
//   ovf_sticky=1; once sticky, acc forced to 0x7F800000 (sign of first overflowing term) for rest of vector.
//  DONE: dataout=acc, overflow_flag=ovf_sticky; both held until next DONE or reset.
//  Reset mid-operation: immediate return to reset values; partial vector discarded, next accept is element 0.
//  NaN not propagated: NaN input handled as overflow (result infinity, flag=1).
// STRUCTURE
//  Package fp32_pkg: FP_EXP_W=8, FP_MAN_W=23, FP_BIAS=127, FP_POS_INF=32'h7F800000, FP_ZERO,
//   state enum {IDLE, ALIGN, ADD, NORM, DONE}, unpack/pack field helpers.
//  Sub-module fp_lzc (25-bit leading-zero counter, 5-bit count, combinational) instantiated in NORM path.
//  All other logic (FSM, aligner, adder, counter, output regs) in this module.
// TESTING (VEC_LEN=4)
//  4x 0x40F00000 (7.5) -> dataout=0x41F00000 (30.0), overflow_flag=0, one dataout_valid pulse.
//  0x40F00000, 0xC0F00000, 0x40400000, 0x00000000 -> 0x40400000 (3.0), overflow_flag=0 (cancellation to +0 mid-way).
//  4x 0x7F7FFFFF -> exponent overflow on 2nd add -> dataout=0x7F800000, overflow_flag=1.
//  0x3FC00000 with datain_ovf=1 then 3x 0x3F800000 -> 0x7F800000, overflow_flag=1; next vector 4x 0x3F800000
//   -> 0x40800000 (4.0), overflow_flag=0 (sticky cleared).
//  datain_valid held 2 cycles per operand 0x40000000 (2.0): ready drops after accept, 4 accepts total
//   -> 0x41000000 (8.0); check latency = 4 cycles accept->dataout_valid on last element.
//  Accept 2 elements of 0x3F800000, pull reset low 1 cycle -> all outputs 0, ready=1; then 4x 0x3F800000 -> 0x40800000.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared FP32 field widths, constants, the accumulator state encoding and
// the unpack/pack helpers used by the dot-product accumulator.
package fp32_pkg;

   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;
   localparam int FP_BIAS  = 127;

   localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
   localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      ADD,
      NORM,
      DONE
   } state_t;

   // Sign, biased exponent and 24-bit mantissa with the hidden bit restored.
   typedef struct packed {
      logic                sign;
      logic [FP_EXP_W-1:0] exp;
      logic [FP_MAN_W:0]   man;
   } fp_unpacked_t;

   // A zero exponent field means zero or denormal; both are treated as zero.
   function automatic fp_unpacked_t fp_unpack(input logic [31:0] value);
      fp_unpacked_t u;
      u.sign = value[31];
      u.exp  = value[30:23];
      u.man  = (value[30:23] == '0) ? '0 : {1'b1, value[22:0]};
      return u;
   endfunction

   function automatic logic [31:0] fp_pack(input logic                sign,
                                           input logic [FP_EXP_W-1:0] exp,
                                           input logic [FP_MAN_W-1:0] frac);
      return {sign, exp, frac};
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational 25-bit leading-zero counter used by the normalise step.
module fp_lzc (
   input  logic [24:0] value,
   output logic [4:0]  zeros
);

   // Scan upwards so the highest set bit is the one that determines the count.
   always_comb begin
      zeros = 5'd25;
      for (int i = 0; i < 25; i++) begin
         if (value[i]) begin
            zeros = 5'(24 - i);
         end
      end
   end

endmodule

// File: rtl/fp32_dot_accumulator.sv
// Accumulates VEC_LEN consecutive FP32 products into one single-precision sum
// using a multi-cycle align/add/normalise sequence with truncating rounding.
module fp32_dot_accumulator
   import fp32_pkg::*;
#(
   parameter int VEC_LEN = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        datain_valid,
   input  logic [31:0] datain,
   input  logic        datain_ovf,
   output logic        datain_ready,
   output logic [31:0] dataout,
   output logic        dataout_valid,
   output logic        overflow_flag
);

   localparam int              CNT_W    = $clog2(VEC_LEN);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

   state_t state, state_next;

   logic [31:0]      acc;
   logic [CNT_W-1:0] count;
   logic             ovf_sticky;
   logic             last_elem;
   logic             accept;

   logic [31:0] op_data;
   logic        op_bad;

   fp_unpacked_t        acc_u, op_u;
   logic                acc_is_big;
   logic [FP_EXP_W-1:0] exp_diff;
   logic [FP_MAN_W:0]   small_raw;
   logic [FP_MAN_W:0]   small_shifted;

   logic [FP_EXP_W-1:0] al_exp;
   logic                al_sign_big, al_sign_small;
   logic [FP_MAN_W:0]   al_man_big, al_man_small;

   logic [24:0]         add_man;
   logic                add_sign;

   logic [FP_EXP_W-1:0] sum_exp;
   logic                sum_sign;
   logic [24:0]         sum_man;

   logic [4:0]          lz;
   logic signed [9:0]   norm_exp;
   logic [FP_MAN_W-1:0] norm_frac;
   logic [31:0]         norm_result;
   logic                norm_ovf;

   logic [31:0] acc_next;
   logic        sticky_next;

   assign last_elem = (count == LAST_IDX);
   assign accept    = datain_valid & datain_ready;
   assign acc_u     = fp_unpack(acc);
   assign op_u      = fp_unpack(op_data);

   // The trailing 1 caps the count at 24 so only the 24-bit mantissa is measured.
   fp_lzc u_lzc (
      .value ({sum_man[23:0], 1'b1}),
      .zeros (lz)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; the block only takes a product while sitting in IDLE.
   always_comb begin
      state_next   = state;
      datain_ready = 1'b0;
      case (state)
         IDLE: begin
            datain_ready = 1'b1;
            if (datain_valid) begin
               state_next = ALIGN;
            end
         end
         ALIGN:   state_next = ADD;
         ADD:     state_next = NORM;
         NORM:    state_next = last_elem ? DONE : IDLE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Align: the larger exponent wins and the other mantissa is truncated right.
   always_comb begin
      acc_is_big    = (acc_u.exp >= op_u.exp);
      exp_diff      = acc_is_big ? (acc_u.exp - op_u.exp) : (op_u.exp - acc_u.exp);
      small_raw     = acc_is_big ? op_u.man : acc_u.man;
      small_shifted = (exp_diff >= 8'd25) ? '0 : (small_raw >> exp_diff);
   end

   // Add: same signs add; otherwise the larger magnitude minus the smaller.
   always_comb begin
      add_man  = '0;
      add_sign = al_sign_big;
      if (al_sign_big == al_sign_small) begin
         add_man = {1'b0, al_man_big} + {1'b0, al_man_small};
      end else if (al_man_big >= al_man_small) begin
         add_man = {1'b0, al_man_big - al_man_small};
      end else begin
         add_man  = {1'b0, al_man_small - al_man_big};
         add_sign = al_sign_small;
      end
   end

   // Normalise the sum, flushing underflow to signed zero and overflow to infinity.
   always_comb begin
      norm_exp    = '0;
      norm_frac   = '0;
      norm_result = FP_ZERO;
      norm_ovf    = 1'b0;
      if (sum_man != '0) begin
         if (sum_man[24]) begin
            norm_exp  = $signed({2'b00, sum_exp}) + 10'sd1;
            norm_frac = sum_man[23:1];
         end else begin
            norm_exp  = $signed({2'b00, sum_exp}) - $signed({5'd0, lz});
            norm_frac = sum_man[22:0] << lz;
         end
         if (norm_exp <= 10'sd0) begin
            norm_result = fp_pack(sum_sign, '0, '0);
         end else if (norm_exp >= 10'sd255) begin
            norm_result = FP_POS_INF | {sum_sign, 31'd0};
            norm_ovf    = 1'b1;
         end else begin
            norm_result = fp_pack(sum_sign, norm_exp[7:0], norm_frac);
         end
      end
   end

   // Once a vector has overflowed its accumulator stays at the first infinity seen.
   always_comb begin
      acc_next    = norm_result;
      sticky_next = ovf_sticky;
      if (ovf_sticky) begin
         acc_next = acc;
      end else if (op_bad) begin
         acc_next    = FP_POS_INF | {op_data[31], 31'd0};
         sticky_next = 1'b1;
      end else if (norm_ovf) begin
         sticky_next = 1'b1;
      end
   end

   // Operand capture and the align/add pipeline registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_data       <= '0;
         op_bad        <= 1'b0;
         al_exp        <= '0;
         al_sign_big   <= 1'b0;
         al_sign_small <= 1'b0;
         al_man_big    <= '0;
         al_man_small  <= '0;
         sum_exp       <= '0;
         sum_sign      <= 1'b0;
         sum_man       <= '0;
      end else begin
         if (accept) begin
            op_data <= datain;
            op_bad  <= datain_ovf | (datain[30:23] == {FP_EXP_W{1'b1}});
         end
         if (state == ALIGN) begin
            al_exp        <= acc_is_big ? acc_u.exp : op_u.exp;
            al_sign_big   <= acc_is_big ? acc_u.sign : op_u.sign;
            al_sign_small <= acc_is_big ? op_u.sign : acc_u.sign;
            al_man_big    <= acc_is_big ? acc_u.man : op_u.man;
            al_man_small  <= small_shifted;
         end
         if (state == ADD) begin
            sum_exp  <= al_exp;
            sum_sign <= add_sign;
            sum_man  <= add_man;
         end
      end
   end

   // Accumulator, element counter and overflow sticky; cleared when leaving DONE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc        <= FP_ZERO;
         count      <= '0;
         ovf_sticky <= 1'b0;
      end else if (state == NORM) begin
         acc        <= acc_next;
         ovf_sticky <= sticky_next;
         if (!last_elem) begin
            count <= count + 1'b1;
         end
      end else if (state == DONE) begin
         acc        <= FP_ZERO;
         count      <= '0;
         ovf_sticky <= 1'b0;
      end
   end

   // Result registers: loaded as the last element finishes, held until the next result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dataout       <= FP_ZERO;
         overflow_flag <= 1'b0;
         dataout_valid <= 1'b0;
      end else begin
         dataout_valid <= 1'b0;
         if (state == NORM && last_elem) begin
            dataout       <= acc_next;
            overflow_flag <= sticky_next;
            dataout_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fp32_dot_accumulator.sv
// Scoreboard bench for fp32_dot_accumulator: a driver feeds products and a
// value-level reference model queues expected sums; a monitor checks each pulse.
module tb_fp32_dot_accumulator;

   localparam int VEC = 4;

   logic        clk;
   logic        reset;
   logic        datain_valid;
   logic [31:0] datain;
   logic        datain_ovf;
   logic        datain_ready;
   logic [31:0] dataout;
   logic        dataout_valid;
   logic        overflow_flag;

   int total = 0;
   int bad   = 0;
   int cycle = 0;

   typedef struct {
      logic [31:0] value;
      logic        flag;
      int          acceptAt;
   } expect_t;

   expect_t     expQ[$];
   logic [31:0] modelAcc;
   bit          modelSticky;
   int          modelCount;

   fp32_dot_accumulator #(.VEC_LEN(VEC)) dut (
      .clk           (clk),
      .reset         (reset),
      .datain_valid  (datain_valid),
      .datain        (datain),
      .datain_ovf    (datain_ovf),
      .datain_ready  (datain_ready),
      .dataout       (dataout),
      .dataout_valid (dataout_valid),
      .overflow_flag (overflow_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      total++;
      if (actual !== required) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, required, $time);
      end
   endtask

   // Value-level FP32 addition: integer mantissas scaled to a common exponent,
   // truncating alignment, exact signed sum, then renormalisation.
   function automatic logic [31:0] refAdd(input logic [31:0] a, input logic [31:0] b, output bit ovf);
      int     ea, eb, e;
      longint ma, mb, s, m;
      bit     neg;
      logic [31:0] r;
      ovf = 1'b0;
      ea  = int'(a[30:23]);
      eb  = int'(b[30:23]);
      ma  = (ea == 0) ? 64'sd0 : longint'({1'b1, a[22:0]});
      mb  = (eb == 0) ? 64'sd0 : longint'({1'b1, b[22:0]});
      e   = (ea > eb) ? ea : eb;
      ma  = ((e - ea) >= 25) ? 64'sd0 : (ma >> (e - ea));
      mb  = ((e - eb) >= 25) ? 64'sd0 : (mb >> (e - eb));
      if (a[31]) ma = -ma;
      if (b[31]) mb = -mb;
      s = ma + mb;
      if (s == 0) return 32'h0000_0000;
      neg = (s < 0);
      m   = neg ? -s : s;
      while (m >= 64'sd16777216) begin
         m = m >> 1;
         e++;
      end
      while (m < 64'sd8388608) begin
         m = m << 1;
         e--;
      end
      if (e <= 0) return {neg, 31'd0};
      if (e >= 255) begin
         ovf = 1'b1;
         return {neg, 8'hFF, 23'd0};
      end
      r = {neg, e[7:0], m[22:0]};
      return r;
   endfunction

   task automatic resetModel();
      modelAcc    = 32'h0;
      modelSticky = 1'b0;
      modelCount  = 0;
   endtask

   task automatic modelElement(input logic [31:0] data, input logic ovf, input int acceptAt);
      bit      o;
      expect_t e;
      if (!modelSticky) begin
         if (ovf || data[30:23] == 8'hFF) begin
            modelSticky = 1'b1;
            modelAcc    = {data[31], 8'hFF, 23'd0};
         end else begin
            modelAcc = refAdd(modelAcc, data, o);
            if (o) modelSticky = 1'b1;
         end
      end
      modelCount++;
      if (modelCount == VEC) begin
         e.value    = modelAcc;
         e.flag     = modelSticky;
         e.acceptAt = acceptAt;
         expQ.push_back(e);
         resetModel();
      end
   endtask

   // Offers one product, waits for ready, then optionally keeps valid high for
   // extra cycles during which the block must not take it again.
   task automatic applyStimulus(input logic [31:0] data, input logic ovf, input int hold);
      int waitCount;
      waitCount = 0;
      @(negedge clk);
      datain       = data;
      datain_ovf   = ovf;
      datain_valid = 1'b1;
      while (!datain_ready) begin
         @(negedge clk);
         waitCount++;
         if (waitCount > 50) begin
            total++;
            bad++;
            $display("[TB] FAIL ready timeout: ready stuck at %0b, expected 1 within 50 cycles", datain_ready);
            datain_valid = 1'b0;
            return;
         end
      end
      @(negedge clk);
      modelElement(data, ovf, cycle);
      for (int h = 1; h < hold; h++) begin
         checkOutput("ready low while busy", 32'(datain_ready), 32'd0);
         @(negedge clk);
      end
      datain_valid = 1'b0;
      datain_ovf   = 1'b0;
      datain       = $urandom;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " ready"},         32'(datain_ready),  32'd1);
      checkOutput({tag, " dataout"},       dataout,            32'd0);
      checkOutput({tag, " dataout_valid"}, 32'(dataout_valid), 32'd0);
      checkOutput({tag, " overflow_flag"}, 32'(overflow_flag), 32'd0);
   endtask

   task automatic applyReset();
      @(negedge clk);
      reset        = 1'b0;
      datain_valid = 1'b0;
      #1;
      checkResetState("mid reset");
      @(negedge clk);
      reset = 1'b1;
      resetModel();
   endtask

   function automatic logic [31:0] randOperand();
      int          sel;
      logic [31:0] v;
      sel = $urandom_range(0, 19);
      v   = $urandom;
      case (sel)
         0:       v = {v[31], 31'd0};
         1:       v = {v[31], 8'h00, v[22:0]};
         2:       v = {v[31], 8'hFF, v[22:0]};
         3:       v = {v[31], 8'(250 + $urandom_range(0, 4)), v[22:0]};
         default: v = {v[31], 8'(118 + $urandom_range(0, 18)), v[22:0]};
      endcase
      return v;
   endfunction

   // Monitor: every result pulse must match the oldest queued expectation,
   // including the accept-to-result latency of the final element.
   initial begin
      expect_t e;
      forever begin
         @(negedge clk);
         if (reset && dataout_valid) begin
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected result: dataout_valid=1 with dataout=0x%08h, expected no result", dataout);
            end else begin
               e = expQ.pop_front();
               checkOutput("dataout",       dataout,            e.value);
               checkOutput("overflow_flag", 32'(overflow_flag), 32'(e.flag));
               checkOutput("result latency", 32'(cycle - e.acceptAt), 32'd3);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int waitCount;
      reset        = 1'b0;
      datain_valid = 1'b0;
      datain       = 32'h0;
      datain_ovf   = 1'b0;
      resetModel();
      #2;
      checkResetState("power-on reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;

      for (int k = 0; k < 4; k++) applyStimulus(32'h40F0_0000, 1'b0, 1);

      applyStimulus(32'h40F0_0000, 1'b0, 1);
      applyStimulus(32'hC0F0_0000, 1'b0, 1);
      applyStimulus(32'h4040_0000, 1'b0, 1);
      applyStimulus(32'h0000_0000, 1'b0, 1);

      for (int k = 0; k < 4; k++) applyStimulus(32'h7F7F_FFFF, 1'b0, 1);

      applyStimulus(32'h3FC0_0000, 1'b1, 1);
      for (int k = 0; k < 3; k++) applyStimulus(32'h3F80_0000, 1'b0, 1);
      for (int k = 0; k < 4; k++) applyStimulus(32'h3F80_0000, 1'b0, 1);

      for (int k = 0; k < 4; k++) applyStimulus(32'h4000_0000, 1'b0, 2);

      repeat (6) @(negedge clk);
      applyStimulus(32'h3F80_0000, 1'b0, 1);
      applyStimulus(32'h3F80_0000, 1'b0, 1);
      applyReset();
      for (int k = 0; k < 4; k++) applyStimulus(32'h3F80_0000, 1'b0, 1);

      for (int v = 0; v < 40; v++) begin
         for (int k = 0; k < 4; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            applyStimulus(randOperand(), ($urandom_range(0, 24) == 0), $urandom_range(1, 3));
         end
      end

      waitCount = 0;
      while (expQ.size() != 0 && waitCount < 20) begin
         @(negedge clk);
         waitCount++;
      end
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
